spi_master: RTL
===============

# spi_master

Memory-mapped SPI master peripheral on the shared CPU memory bus, decoded at 0x0007_0000–0x0007_000F alongside the UART, timer, LED and GPIO peripherals. It buffers up to four transmit bytes, runs SPI mode 0 (CPOL=0, CPHA=0, MSB first) at a programmable clock divider, and holds the last received byte for the CPU. Its read value is OR-combined onto the bus read mux and its ready is OR-combined into the bus ready.

## Interface
- DEPTH, 4, TX FIFO entries; power of two, 2..16.
- DIV_RESET, 8'd7, reset value of the divider register.
- clk  in  1  system clock (PLL clock)
- reset  in  1  asynchronous, active-high reset
- address_in  in  32  bus address; only [3:2] decoded internally
- sel_in  in  1  peripheral select from top-level decode
- read_in  in  1  bus read strobe
- read_value_out  out  32  register read data; 0 when sel_in=0
- write_mask_in  in  4  byte write enables; nonzero = write
- write_value_in  in  32  bus write data
- ready_out  out  1  = sel_in (combinational, single-cycle access)
- sclk_out  out  1  SPI clock, idles low
- mosi_out  out  1  SPI data out
- miso_in  in  1  SPI data in
- csn_out  out  1  chip select, active low, software controlled

## Operation
- Registers (address_in[3:2]); writes take effect at clk edge when sel_in=1 and write_mask_in[0]=1:
  - 0 DATA: write pushes write_value_in[7:0] into TX FIFO; read returns {24'b0, rx_data}; read (sel_in & read_in) clears rx_valid.
  - 1 STATUS (RO except W1C): [0] busy, [1] rx_valid, [2] tx_full, [3] tx_empty, [4] rx_overrun (W1C), [5] tx_overflow (W1C), [12:8] fifo count; others 0.
  - 2 DIV: [7:0] half-period minus one; half-period = DIV+1 clk cycles.
  - 3 CS: [0] drives csn_out directly (1 = deasserted).
- busy = (state != IDLE) | (fifo count != 0).
- FSM states IDLE, LOW, HIGH:
  - IDLE: fifo non-empty -> pop, load shift register, mosi_out = bit7, bit counter=0, phase counter=DIV, go LOW.
  - LOW: sclk_out=0; phase counter hits 0 -> sclk_out=1, sample miso_in into rx shift LSB, reload counter, go HIGH.
  - HIGH: counter hits 0 -> sclk_out=0; if bit counter=7: rx_data <= assembled byte, rx_overrun |= rx_valid, rx_valid=1, go IDLE; else shift, mosi_out = next bit, increment bit counter, go LOW.
- Push to full FIFO: byte dropped, tx_overflow=1. Push and pop same cycle: count unchanged, both succeed (full FIFO with simultaneous pop accepts write).
- DATA read coinciding with byte completion: rx_valid stays 1 with new byte, rx_overrun not set (read value is old byte).
- DIV/CS writes mid-transfer take effect immediately; CS never auto-toggles.
- miso_in sampled directly (slave is synchronous to sclk_out).

## Timing
- Reset values: sclk_out=0, mosi_out=0, csn_out=1, read_value_out=0, DIV=DIV_RESET, FIFO empty, rx_data=0, all flags 0, state IDLE.
- Reset asserted mid-transfer: immediately aborts; outputs return to reset values asynchronously, no rx update.
- Byte time: 1 load cycle + 16*(DIV+1) cycles; back-to-back bytes add the 1 IDLE load cycle between them (sclk low for DIV+2 cycles).
- Write of DATA at edge N, FSM IDLE, FIFO empty: count=1 after N, load at N+1, first sclk rise at N+1+(DIV+1), rx_valid set at N+1+16*(DIV+1).
- mosi_out changes only on sclk falling edge cycle or load cycle; stable across every rising edge.
- Register reads combinational from current state; ready_out same cycle.

## Test plan
- Reset: assert reset mid-byte with DIV=3 -> sclk_out=0, csn_out=1, STATUS=0x0000_0008, DIV reads 7.
- Loopback (miso_in=mosi_out), DIV=0, write CS=0, DATA=0xA5 -> 8 sclk pulses of 1 cycle high, rx_valid at 17 cycles after write, DATA reads 0x000000A5, then STATUS[1]=0.
- MISO pattern 0x3C driven by bench slave model, DIV=2, TX 0xFF -> rx 0x3C, sclk half-period 3 cycles, mosi constant 1.
- FIFO: DIV=7, write 6 bytes in consecutive cycles -> first popped, 4 queued, 6th dropped, tx_overflow=1, count=4; W1C 0x20 clears it; all 5 accepted bytes appear on mosi in order.
- Overrun: send two bytes without reading DATA -> rx_overrun=1, DATA=second byte; write STATUS 0x10 clears.
- Bus hygiene: sel_in=0 with any address/mask -> read_value_out=0, ready_out=0, no register change.

Source files
------------

// File: rtl/spi_master.sv
// Memory-mapped SPI master (mode 0, MSB first) with a small TX FIFO and a
// single-byte RX holding register, programmable sclk divider and software CS.
module spi_master #(
    parameter int          DEPTH     = 4,
    parameter logic [7:0]  DIV_RESET = 8'd7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic        sclk_out,
    output logic        mosi_out,
    input  logic        miso_in,
    output logic        csn_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

    state_t      r_state, w_state_nx;
    logic [7:0]  r_cnt, w_cnt_nx;
    logic [2:0]  r_bit, w_bit_nx;
    logic [7:0]  r_tx_sh, w_tx_nx;
    logic [7:0]  r_rx_sh, w_rx_nx;
    logic        r_sclk, w_sclk_nx;
    logic        r_mosi, w_mosi_nx;
    logic        w_pop, w_done;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    w_head;

    logic [7:0]  r_div;
    logic        r_cs;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid, r_rx_overrun, r_tx_overflow;

    logic w_wr, w_wr_data, w_wr_stat, w_wr_div, w_wr_cs, w_rd_data;
    logic w_full, w_empty, w_busy, w_push_ok;
    logic w_unused;

    assign w_wr      = sel_in & write_mask_in[0];
    assign w_wr_data = w_wr & (address_in[3:2] == 2'd0);
    assign w_wr_stat = w_wr & (address_in[3:2] == 2'd1);
    assign w_wr_div  = w_wr & (address_in[3:2] == 2'd2);
    assign w_wr_cs   = w_wr & (address_in[3:2] == 2'd3);
    assign w_rd_data = sel_in & read_in & (address_in[3:2] == 2'd0);

    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_busy    = (r_state != S_IDLE) | ~w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign w_push_ok = w_wr_data & (~w_full | w_pop);
    assign w_head    = r_mem[r_rd_ptr];

    assign w_unused = ^{address_in[31:4], address_in[1:0], write_mask_in[3:1],
                        write_value_in[31:8]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx_sh <= '0;
            r_rx_sh <= '0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_tx_sh <= w_tx_nx;
            r_rx_sh <= w_rx_nx;
            r_sclk  <= w_sclk_nx;
            r_mosi  <= w_mosi_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        w_tx_nx    = r_tx_sh;
        w_rx_nx    = r_rx_sh;
        w_sclk_nx  = r_sclk;
        w_mosi_nx  = r_mosi;
        w_pop      = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_tx_nx    = w_head;
                    w_mosi_nx  = w_head[7];
                    w_bit_nx   = '0;
                    w_cnt_nx   = r_div;
                    w_state_nx = S_LOW;
                end
            end
            S_LOW: begin
                if (r_cnt == 8'd0) begin
                    w_sclk_nx  = 1'b1;
                    w_rx_nx    = {r_rx_sh[6:0], miso_in};
                    w_cnt_nx   = r_div;
                    w_state_nx = S_HIGH;
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            S_HIGH: begin
                if (r_cnt == 8'd0) begin
                    w_sclk_nx = 1'b0;
                    if (r_bit == 3'd7) begin
                        w_done     = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_tx_nx    = {r_tx_sh[6:0], 1'b0};
                        w_mosi_nx  = r_tx_sh[6];
                        w_bit_nx   = r_bit + 3'd1;
                        w_cnt_nx   = r_div;
                        w_state_nx = S_LOW;
                    end
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= write_value_in[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div         <= DIV_RESET;
            r_cs          <= 1'b1;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_overflow <= 1'b0;
        end else begin
            if (w_wr_div) r_div <= write_value_in[7:0];
            if (w_wr_cs)  r_cs  <= write_value_in[0];
            if (w_wr_stat && write_value_in[4]) r_rx_overrun  <= 1'b0;
            if (w_wr_stat && write_value_in[5]) r_tx_overflow <= 1'b0;
            if (w_wr_data && w_full && !w_pop)  r_tx_overflow <= 1'b1;
            // A DATA read landing on the completion edge consumes the old byte, so no overrun.
            if (w_done) begin
                r_rx_data  <= r_rx_sh;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !w_rd_data) r_rx_overrun <= 1'b1;
            end else if (w_rd_data) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        read_value_out = '0;
        if (sel_in) begin
            case (address_in[3:2])
                2'd0: read_value_out = {24'b0, r_rx_data};
                2'd1: read_value_out = {19'b0, 5'(r_count), 2'b0, r_tx_overflow,
                                        r_rx_overrun, w_empty, w_full, r_rx_valid, w_busy};
                2'd2: read_value_out = {24'b0, r_div};
                default: read_value_out = {31'b0, r_cs};
            endcase
        end
    end

    assign ready_out = sel_in;
    assign sclk_out  = r_sclk;
    assign mosi_out  = r_mosi;
    assign csn_out   = r_cs;

endmodule
